// File: rtl/puf_multi_timer.sv
// puf_multi_timer: NUM_CH independent pulse timers that drive PUF excitation.
// Each channel holds its ctrl output high for T cycles, then strobes done.
// A channel either stops there (one-shot) or inserts a one-cycle gap and
// starts again (periodic).
module puf_multi_timer #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_CH-1:0]         enable,
   input  logic [NUM_CH-1:0]         mode,
   input  logic [NUM_CH*CNT_W-1:0]   target,
   output logic [NUM_CH-1:0]         ctrl,
   output logic [NUM_CH-1:0]         done,
   output logic [NUM_CH*CNT_W-1:0]   count_o,
   output logic                      busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_GAP  = 2'd2,
      ST_HOLD = 2'd3
   } state_e;

   // Next-cycle ctrl of every channel; busy is registered from it so that
   // busy lines up with ctrl.
   logic [NUM_CH-1:0] ctrl_d;
   logic              busy_q;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      state_e           state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [CNT_W-1:0] tgt_q, tgt_d;
      logic [CNT_W-1:0] tgt_in;
      logic             mode_q, mode_d;
      logic             ctrl_q, ctrl_ch_d;
      logic             done_q, done_d;

      assign tgt_in = target[i*CNT_W +: CNT_W];

      // Channel state register, async reset to an idle channel.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tgt_q   <= '0;
            mode_q  <= 1'b0;
            ctrl_q  <= 1'b0;
            done_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            mode_q  <= mode_d;
            ctrl_q  <= ctrl_ch_d;
            done_q  <= done_d;
         end
      end

      // Channel next-state: target and mode are sampled only in IDLE and GAP.
      // RUN stops at cnt == tgt, so the counter never wraps.
      always_comb begin
         state_d   = state_q;
         cnt_d     = cnt_q;
         tgt_d     = tgt_q;
         mode_d    = mode_q;
         ctrl_ch_d = 1'b0;
         done_d    = 1'b0;
         if (!enable[i]) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end else begin
            case (state_q)
               ST_IDLE, ST_GAP: begin
                  tgt_d  = tgt_in;
                  mode_d = mode[i];
                  if (tgt_in != '0) begin
                     state_d   = ST_RUN;
                     cnt_d     = CNT_W'(1);
                     ctrl_ch_d = 1'b1;
                  end else begin
                     state_d = ST_HOLD;
                     cnt_d   = '0;
                     done_d  = 1'b1;
                  end
               end
               ST_RUN: begin
                  if (cnt_q == tgt_q) begin
                     done_d = 1'b1;
                     if (mode_q) begin
                        state_d = ST_GAP;
                        cnt_d   = '0;
                     end else begin
                        state_d = ST_HOLD;
                     end
                  end else begin
                     cnt_d     = cnt_q + CNT_W'(1);
                     ctrl_ch_d = 1'b1;
                  end
               end
               ST_HOLD: begin
                  state_d = ST_HOLD;
               end
               default: begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            endcase
         end
      end

      assign ctrl_d[i]                   = ctrl_ch_d;
      assign ctrl[i]                     = ctrl_q;
      assign done[i]                     = done_q;
      assign count_o[i*CNT_W +: CNT_W]   = cnt_q;
   end

   // Registered OR of all channel ctrl bits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q <= 1'b0;
      end else begin
         busy_q <= |ctrl_d;
      end
   end

   assign busy = busy_q;

endmodule

// File: tb/tb_puf_multi_timer.sv
// Directed bench for puf_multi_timer (4 channels, 16-bit counters).
module tb_puf_multi_timer;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned CNT_W  = 16;

   logic                    clk;
   logic                    rst;
   logic [NUM_CH-1:0]       enable;
   logic [NUM_CH-1:0]       mode;
   logic [NUM_CH*CNT_W-1:0] target;
   logic [NUM_CH-1:0]       ctrl;
   logic [NUM_CH-1:0]       done;
   logic [NUM_CH*CNT_W-1:0] count_o;
   logic                    busy;

   int errors = 0;
   int checks = 0;

   puf_multi_timer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .mode    (mode),
      .target  (target),
      .ctrl    (ctrl),
      .done    (done),
      .count_o (count_o),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] cnt(input int ch);
      return 32'(count_o[ch*CNT_W +: CNT_W]);
   endfunction

   task automatic set_t(input int ch, input logic [CNT_W-1:0] t);
      target[ch*CNT_W +: CNT_W] = t;
   endtask

   initial begin
      bit ok;
      rst    = 1'b0;
      enable = '0;
      mode   = '0;
      target = '0;

      // Reset state
      tick();
      tick();
      chk("rst_ctrl", 32'(ctrl), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_count", 32'(count_o[31:0]), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b1;
      tick();
      chk("idle_ctrl", 32'(ctrl), 32'd0);

      // ch0 one-shot, T=15
      set_t(0, 16'd15);
      mode[0]   = 1'b0;
      enable[0] = 1'b1;
      ok = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         tick();
         if (ctrl[0] !== 1'b1 || cnt(0) !== 32'(k) || done[0] !== 1'b0 || busy !== 1'b1) ok = 1'b0;
      end
      chk("ch0_run15", 32'(ok), 32'd1);
      tick();
      chk("ch0_end_ctrl", 32'(ctrl[0]), 32'd0);
      chk("ch0_end_done", 32'(done[0]), 32'd1);
      chk("ch0_end_cnt", cnt(0), 32'd15);
      chk("ch0_end_busy", 32'(busy), 32'd0);
      tick();
      tick();
      chk("ch0_hold_done", 32'(done[0]), 32'd0);
      chk("ch0_hold_ctrl", 32'(ctrl[0]), 32'd0);
      chk("ch0_hold_cnt", cnt(0), 32'd15);
      enable[0] = 1'b0;
      tick();
      chk("ch0_off_cnt", cnt(0), 32'd0);

      // ch0 periodic T=15; target changed to 5 mid-run
      mode[0]   = 1'b1;
      enable[0] = 1'b1;
      ok = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         tick();
         if (k == 3) set_t(0, 16'd5);
         if (ctrl[0] !== 1'b1 || cnt(0) !== 32'(k)) ok = 1'b0;
      end
      chk("ch0_per_run15", 32'(ok), 32'd1);
      tick();
      chk("ch0_gap_ctrl", 32'(ctrl[0]), 32'd0);
      chk("ch0_gap_done", 32'(done[0]), 32'd1);
      chk("ch0_gap_cnt", cnt(0), 32'd0);
      ok = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (ctrl[0] !== 1'b1 || cnt(0) !== 32'(k) || done[0] !== 1'b0) ok = 1'b0;
      end
      chk("ch0_per_run5", 32'(ok), 32'd1);
      tick();
      chk("ch0_gap2_done", 32'(done[0]), 32'd1);
      chk("ch0_gap2_ctrl", 32'(ctrl[0]), 32'd0);
      enable[0] = 1'b0;
      tick();
      chk("ch0_off2_cnt", cnt(0), 32'd0);

      // ch1 periodic T=3 for 20 cycles: 1,1,1,0 pattern
      set_t(1, 16'd3);
      mode[1]   = 1'b1;
      enable[1] = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         chk($sformatf("ch1_ctrl_c%0d", c), 32'(ctrl[1]), (c % 4 != 0) ? 32'd1 : 32'd0);
         chk($sformatf("ch1_done_c%0d", c), 32'(done[1]), (c % 4 == 0) ? 32'd1 : 32'd0);
         chk($sformatf("ch1_busy_c%0d", c), 32'(busy), (c % 4 != 0) ? 32'd1 : 32'd0);
         chk($sformatf("ch1_cnt_c%0d", c), cnt(1), 32'(c % 4));
      end
      enable[1] = 1'b0;
      tick();
      chk("ch1_off_ctrl", 32'(ctrl[1]), 32'd0);
      chk("ch1_off_done", 32'(done[1]), 32'd0);

      // ch2 T=0: no ctrl, single done, HOLD
      set_t(2, 16'd0);
      mode[2]   = 1'b1;
      enable[2] = 1'b1;
      tick();
      chk("ch2_t0_ctrl", 32'(ctrl[2]), 32'd0);
      chk("ch2_t0_done", 32'(done[2]), 32'd1);
      ok = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (ctrl[2] !== 1'b0 || done[2] !== 1'b0 || busy !== 1'b0) ok = 1'b0;
      end
      chk("ch2_t0_hold", 32'(ok), 32'd1);
      enable[2] = 1'b0;
      tick();
      chk("ch2_off_cnt", cnt(2), 32'd0);

      // ch3 T=100 aborted after 40, then full run
      set_t(3, 16'd100);
      mode[3]   = 1'b0;
      enable[3] = 1'b1;
      ok = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (ctrl[3] !== 1'b1 || cnt(3) !== 32'(k)) ok = 1'b0;
      end
      chk("ch3_run40", 32'(ok), 32'd1);
      enable[3] = 1'b0;
      tick();
      chk("ch3_abort_ctrl", 32'(ctrl[3]), 32'd0);
      chk("ch3_abort_cnt", cnt(3), 32'd0);
      chk("ch3_abort_done", 32'(done[3]), 32'd0);
      tick();
      chk("ch3_abort_done2", 32'(done[3]), 32'd0);
      enable[3] = 1'b1;
      ok = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         tick();
         if (ctrl[3] !== 1'b1 || cnt(3) !== 32'(k) || done[3] !== 1'b0) ok = 1'b0;
      end
      chk("ch3_run100", 32'(ok), 32'd1);
      tick();
      chk("ch3_end_done", 32'(done[3]), 32'd1);
      chk("ch3_end_cnt", cnt(3), 32'd100);
      enable[3] = 1'b0;
      tick();

      // All four started together, async reset mid-run, restart on release
      for (int ch = 0; ch < 4; ch++) set_t(ch, 16'd20);
      mode   = 4'b0000;
      enable = 4'b1111;
      for (int k = 1; k <= 5; k++) tick();
      chk("all_ctrl_aligned", 32'(ctrl), 32'hF);
      chk("all_cnt_hi", 32'(count_o[63:32]), 32'h0005_0005);
      chk("all_cnt_lo", 32'(count_o[31:0]), 32'h0005_0005);
      #2;
      rst = 1'b0;
      #1;
      chk("async_ctrl", 32'(ctrl), 32'd0);
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_cnt_hi", 32'(count_o[63:32]), 32'd0);
      chk("async_cnt_lo", 32'(count_o[31:0]), 32'd0);
      chk("async_done", 32'(done), 32'd0);
      tick();
      chk("rst_held_ctrl", 32'(ctrl), 32'd0);
      rst = 1'b1;
      tick();
      chk("rel_ctrl", 32'(ctrl), 32'hF);
      chk("rel_cnt0", cnt(0), 32'd1);
      chk("rel_busy", 32'(busy), 32'd1);
      enable = 4'b0000;
      tick();
      chk("all_off_ctrl", 32'(ctrl), 32'd0);

      // Boundary: T=65535 one-shot, no wrap
      set_t(0, 16'hFFFF);
      mode[0]   = 1'b0;
      enable[0] = 1'b1;
      ok = 1'b1;
      for (int k = 1; k <= 65535; k++) begin
         tick();
         if (ctrl[0] !== 1'b1 || cnt(0) !== 32'(k)) ok = 1'b0;
      end
      chk("max_run", 32'(ok), 32'd1);
      tick();
      chk("max_end_ctrl", 32'(ctrl[0]), 32'd0);
      chk("max_end_done", 32'(done[0]), 32'd1);
      chk("max_end_cnt", cnt(0), 32'd65535);
      tick();
      tick();
      chk("max_hold_cnt", cnt(0), 32'd65535);
      chk("max_hold_ctrl", 32'(ctrl[0]), 32'd0);
      enable[0] = 1'b0;
      tick();
      chk("max_off_cnt", cnt(0), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/puf_multi_timer.md
PUF_MULTI_TIMER -- requirements
Module: puf_multi_timer

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent timer channels, legal range 1..16.
REQ-002 Parameter CNT_W, default 16: counter and target width in bits, legal range 4..32.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  NUM_CH  per-channel run request, level-sensitive, synchronous to clk.
REQ-006 mode  input  NUM_CH  per-channel mode: 0 one-shot, 1 periodic; sampled only at channel start.
REQ-007 target  input  NUM_CH*CNT_W  per-channel high-time T in cycles, channel i at bits [i*CNT_W +: CNT_W]; sampled only at channel start.
REQ-008 ctrl  output  NUM_CH  per-channel registered control pulse to the PUF excitation logic.
REQ-009 done  output  NUM_CH  per-channel single-cycle completion strobe, registered.
REQ-010 count_o  output  NUM_CH*CNT_W  per-channel current counter value, same packing as target.
REQ-011 busy  output  1  OR of all ctrl bits, registered (same cycle as ctrl).

Function
REQ-012 Each channel SHALL be an independent FSM with states IDLE, RUN, GAP, HOLD; channels share no state.
REQ-013 IDLE: ctrl=0, count=0; on enable=1 with latched-to-be target T>0 SHALL go to RUN, latch T and mode, set count=1, ctrl=1 on the next edge.
REQ-014 IDLE with enable=1 and T=0: SHALL go to HOLD, ctrl stays 0, done=1 for one cycle (one-shot and periodic alike).
REQ-015 RUN: ctrl=1; count increments by 1 per cycle; when count==T the next edge SHALL clear ctrl, pulse done for one cycle, and go to HOLD (mode 0) or GAP (mode 1).
REQ-016 ctrl SHALL be high for exactly T consecutive cycles per run, first high cycle being the cycle after enable is sampled high in IDLE.
REQ-017 GAP (periodic only): ctrl=0, count=0 for exactly one cycle; then re-sample target and mode and behave as IDLE-start (RUN if T>0, HOLD with done if T=0).
REQ-018 HOLD: ctrl=0, count holds its final value (T); remain until enable=0, then IDLE.
REQ-019 enable=0 in any state SHALL force IDLE on the next edge: ctrl=0, count=0, done=0; an aborted run SHALL NOT pulse done.
REQ-020 Changes to target or mode while in RUN, GAP or HOLD SHALL have no effect until the next sampling point.
REQ-021 Counter SHALL never wrap: T max is 2^CNT_W-1 and count stops at T.
REQ-022 Channels started on the same edge SHALL produce cycle-aligned ctrl for equal T.

Reset
REQ-023 rst=0 SHALL immediately (asynchronously) force all channels to IDLE, ctrl=0, done=0, count_o=0, busy=0, latched T and mode to 0.
REQ-024 Reset deassertion mid-enable: channel SHALL start as from IDLE on the first edge after rst=1 with enable=1.
REQ-025 No output SHALL glitch high during or on release of reset.

Verification
REQ-026 NUM_CH=4, CNT_W=16; ch0 mode 0, T=15, enable held -> ctrl0 high 15 cycles, done0 one pulse on cycle 16, count_o0=15 held, ctrl0 low until enable dropped.
REQ-027 ch1 mode 1, T=3, enable held 20 cycles -> ctrl1 pattern 1,1,1,0 repeating, done1 pulse every 4th cycle, busy follows ctrl1.
REQ-028 ch2 T=0, enable raised -> ctrl2 never high, done2 one pulse, channel in HOLD; drop enable -> count_o2=0 next cycle.
REQ-029 ch3 T=100, enable dropped after 40 ctrl-high cycles -> ctrl3=0 next edge, count_o3=0, no done3 pulse; re-enable -> full 100-cycle run.
REQ-030 All four running, rst pulsed low mid-run -> all outputs 0 asynchronously; target changed from 15 to 5 during ch0 RUN -> run still 15 cycles, next periodic run 5.
REQ-031 Boundary: T=65535 one-shot -> ctrl high 65535 cycles, count_o stops at 65535, no wrap to 0.
